// File: rtl/rv_pkg.sv
// Shared RV32 front-end constants and the fetch FSM state type.
package rv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Memory is combinational, so the instruction at imem_addr is captured on the same edge.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            misalign_err,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] if_pc_reg, if_pc_next;
    logic [XLEN-1:0] if_instr_reg, if_instr_next;
    logic            if_valid_reg, if_valid_next;
    logic            misalign_reg, misalign_next;
    logic [XLEN-1:0] count_reg, count_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    // BOOT holds everything for one cycle; in RUN redirect beats stall beats flush.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        if_pc_next    = if_pc_reg;
        if_instr_next = if_instr_reg;
        if_valid_next = if_valid_reg;
        misalign_next = 1'b0;
        count_next    = count_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_next       = {redirect_pc[XLEN-1:2], 2'b00};
                    if_pc_next    = pc_reg;
                    if_instr_next = NOP_INSTR;
                    if_valid_next = 1'b0;
                    misalign_next = (redirect_pc[1:0] != 2'b00);
                end else if (stall) begin
                    pc_next = pc_reg;
                end else if (flush) begin
                    pc_next       = pc_reg + 32'd4;
                    if_pc_next    = pc_reg;
                    if_instr_next = NOP_INSTR;
                    if_valid_next = 1'b0;
                end else begin
                    pc_next       = pc_reg + 32'd4;
                    if_pc_next    = pc_reg;
                    if_instr_next = imem_instr;
                    if_valid_next = 1'b1;
                    count_next    = count_reg + 32'd1;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            if_pc_reg    <= '0;
            if_instr_reg <= NOP_INSTR;
            if_valid_reg <= 1'b0;
            misalign_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            pc_reg       <= pc_next;
            if_pc_reg    <= if_pc_next;
            if_instr_reg <= if_instr_next;
            if_valid_reg <= if_valid_next;
            misalign_reg <= misalign_next;
            count_reg    <= count_next;
        end
    end

    assign imem_addr    = pc_reg;
    assign if_id_pc     = if_pc_reg;
    assign if_id_instr  = if_instr_reg;
    assign if_id_valid  = if_valid_reg;
    assign misalign_err = misalign_reg;
    assign fetch_count  = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural model plus directed and random stimulus.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, misalign_err;

    logic [31:0] rom [256];
    int          total = 0;
    int          bad = 0;
    bit          started = 1'b0;

    // Model state: what the fetch stage must hold after each edge.
    logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
    logic        m_boot, m_valid, m_mis;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_instr = rom[imem_addr[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= RESET_PC; m_boot <= 1'b1; m_ifpc <= '0; m_instr <= NOP;
            m_valid <= 1'b0; m_mis <= 1'b0; m_cnt <= '0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
            m_mis  <= 1'b0;
        end else begin
            m_mis <= redirect_valid && (redirect_pc % 4 != 0);
            if (redirect_valid) begin
                m_pc <= redirect_pc - (redirect_pc % 4);
                m_ifpc <= m_pc; m_instr <= NOP; m_valid <= 1'b0;
            end else if (!stall) begin
                m_ifpc <= m_pc;
                m_pc   <= m_pc + 4;
                if (flush) begin
                    m_instr <= NOP; m_valid <= 1'b0;
                end else begin
                    m_instr <= rom[m_pc[9:2]]; m_valid <= 1'b1; m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("imem_addr",    imem_addr,            m_pc);
            chk("if_id_pc",     if_id_pc,             m_ifpc);
            chk("if_id_instr",  if_id_instr,          m_instr);
            chk("if_id_valid",  {31'd0, if_id_valid}, {31'd0, m_valid});
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
            chk("fetch_count",  fetch_count,          m_cnt);
        end
    end

    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] p);
        stall = s; flush = f; redirect_valid = r; redirect_pc = p;
        @(negedge clk);
    endtask

    // Drop reset between edges with pending stall/redirect, then release cleanly.
    task automatic mid_cycle_reset(input logic [31:0] p);
        stall = 1'b1; flush = 1'b1; redirect_valid = 1'b1; redirect_pc = p;
        #2 rst_n = 1'b0;
        #1;
        chk("async_imem_addr", imem_addr, RESET_PC);
        chk("async_valid",     {31'd0, if_id_valid}, 32'd0);
        chk("async_instr",     if_id_instr, NOP);
        chk("async_count",     fetch_count, 32'd0);
        chk("async_misalign",  {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h00A0_0113;
        rom[2] = 32'h0020_81B3;
        rom[8] = NOP;

        #2 rst_n = 1'b0;
        started = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 0, 0);
        chk("boot_addr",  imem_addr, RESET_PC);
        chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("first_instr", if_id_instr, 32'h0050_0093);
        chk("first_pc",    if_id_pc, 32'h0);
        step(0, 0, 0, 0);
        chk("second_instr", if_id_instr, 32'h00A0_0113);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("stall_addr",  imem_addr, 32'h8);
        chk("stall_instr", if_id_instr, 32'h00A0_0113);
        chk("stall_count", fetch_count, 32'd2);
        step(0, 0, 0, 0);
        chk("third_instr", if_id_instr, 32'h0020_81B3);
        chk("third_pc",    if_id_pc, 32'h8);
        chk("third_count", fetch_count, 32'd3);
        step(0, 0, 0, 0);
        chk("pre_redir_addr", imem_addr, 32'h10);
        step(0, 0, 1, 32'h20);
        chk("redir_addr",  imem_addr, 32'h20);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("redir_instr", if_id_instr, NOP);
        step(0, 0, 0, 0);
        chk("post_redir_pc",    if_id_pc, 32'h20);
        chk("post_redir_valid", {31'd0, if_id_valid}, 32'd1);
        step(1, 1, 1, 32'h24);
        chk("redir_wins_addr", imem_addr, 32'h24);
        step(0, 0, 1, 32'h22);
        chk("misalign_addr",  imem_addr, 32'h20);
        chk("misalign_pulse", {31'd0, misalign_err}, 32'd1);
        step(0, 0, 0, 0);
        chk("misalign_clear", {31'd0, misalign_err}, 32'd0);
        step(0, 0, 1, 32'h18);
        chk("pre_reset_addr", imem_addr, 32'h18);
        mid_cycle_reset(32'h40);
        step(0, 0, 0, 0);
        chk("reboot_addr",  imem_addr, RESET_PC);
        chk("reboot_valid", {31'd0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("reboot_instr", if_id_instr, 32'h0050_0093);
        chk("reboot_count", fetch_count, 32'd1);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("pc_wrap", imem_addr, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] p;
            p = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 299) == 0) begin
                mid_cycle_reset(p);
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                     $urandom_range(0, 9) == 0, p);
            end
        end
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
